// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester bus plus alu pin bundle for alu_arbiter.
// slave = arbiter view, master = requester/alu environment view.
interface alu_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_result;
  logic              rsp_err;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_op;
  logic              alu_start;
  logic [15:0]       alu_result;
  logic              alu_done;

  modport slave (
    input  req, req_a, req_b, req_op,
    input  alu_result, alu_done,
    output gnt, rsp_valid, rsp_result, rsp_err,
    output alu_a, alu_b, alu_op, alu_start
  );

  modport master (
    output req, req_a, req_b, req_op,
    output alu_result, alu_done,
    input  gnt, rsp_valid, rsp_result, rsp_err,
    input  alu_a, alu_b, alu_op, alu_start
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among NREQ requesters (round-robin, or
// fixed priority with ALU_ARB_FIXED_PRIO_EN defined); watchdog on done.
// Ports: clk, reset_n (async, active low), bus (alu_arbiter_if.slave):
//   req/req_a/req_b/req_op in, gnt/rsp_valid/rsp_result/rsp_err out,
//   alu_a/alu_b/alu_op/alu_start out, alu_result/alu_done in.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   own, own_d;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NREQ-1:0] gnt_d, rv_d;
  logic            start_d, err_d;
  logic [15:0]     res_d;
  logic [7:0]      a_d, b_d;
  logic [2:0]      op_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan: the lowest set index is written last and wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end
`else
  // own doubles as the RR pointer: scan own+NREQ down to own+1 so the
  // index right after the last winner is written last and wins.
  logic [IW:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, own} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (bus.req[idx[IW-1:0]]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state;
    own_d   = own;
    cnt_d   = cnt;
    gnt_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    res_d   = '0;
    a_d     = bus.alu_a;
    b_d     = bus.alu_b;
    op_d    = bus.alu_op;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          start_d    = 1'b1;
          own_d      = win;
          state_d    = ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
              a_d  = bus.req_a[i*8 +: 8];
              b_d  = bus.req_b[i*8 +: 8];
              op_d = bus.req_op[i*3 +: 3];
            end
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done is tested first so it beats the terminal count
        if (bus.alu_done) begin
          rv_d[own] = 1'b1;
          res_d     = bus.alu_result;
          state_d   = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rv_d[own] = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      own            <= IW'(NREQ - 1);
      cnt            <= '0;
      bus.gnt        <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.alu_start  <= 1'b0;
    end else begin
      state          <= state_d;
      own            <= own_d;
      cnt            <= cnt_d;
      bus.gnt        <= gnt_d;
      bus.rsp_valid  <= rv_d;
      bus.rsp_result <= res_d;
      bus.rsp_err    <= err_d;
      bus.alu_a      <= a_d;
      bus.alu_b      <= b_d;
      bus.alu_op     <= op_d;
      bus.alu_start  <= start_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration/alu model.
module tb_alu_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;

  localparam logic [2:0] NO_OP  = 3'd0;
  localparam logic [2:0] ADD_OP = 3'd1;
  localparam logic [2:0] SUB_OP = 3'd2;
  localparam logic [2:0] MUL_OP = 3'd3;

  logic clk;
  logic reset_n;
  logic spur;
  logic done_q;
  logic [15:0] res_q;
  int checks;
  int errors;
  int m_last;
  logic [7:0] ra [NREQ];
  logic [7:0] rb [NREQ];
  logic [2:0] rop [NREQ];

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(logic [2:0] op, logic [7:0] a,
                                        logic [7:0] b);
    case (op)
      3'd1:    return {8'd0, a} + {8'd0, b};
      3'd2:    return {8'd0, a} - {8'd0, b};
      3'd3:    return {8'd0, a} * {8'd0, b};
      3'd4:    return {8'd0, a & b};
      3'd5:    return {8'd0, a | b};
      3'd6:    return {8'd0, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  function automatic logic has_done(logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  // alu model: done one cycle after start, never for no_op / code 7
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.alu_start) begin
        done_q <= has_done(bus.alu_op);
        res_q  <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
      end
    end
  end

  assign bus.alu_done   = done_q | spur;
  assign bus.alu_result = res_q;

  function automatic int exp_winner(logic [NREQ-1:0] r);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++)
      if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++)
      if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(int w);
    return NREQ'(1) << w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op);
    ra[i] = a;
    rb[i] = b;
    rop[i] = op;
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_op[i*3 +: 3] = op;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    bus.req = '0;
    spur = 1'b0;
    m_last = NREQ - 1;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    spur = 1'b0;
    m_last = NREQ - 1;
    tick;
    tick;
    checks++;
    if ({bus.gnt, bus.rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset_gnt_rsp got %h want 0", {bus.gnt, bus.rsp_valid});
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", {bus.rsp_result, bus.rsp_err});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start} !== '0) begin
      errors++;
      $display("FAIL reset_alu got %h want 0",
               {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_add;
    set_op(0, 8'd200, 8'd100, ADD_OP);
    bus.req = 4'b0001;
    tick;
    m_last = 0;
    checks++;
    if ({bus.gnt, bus.alu_start} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL add_gnt got %b/%b want 0001/1", bus.gnt, bus.alu_start);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {8'd200, 8'd100, ADD_OP}) begin
      errors++;
      $display("FAIL add_latch got %h want %h",
               {bus.alu_a, bus.alu_b, bus.alu_op}, {8'd200, 8'd100, ADD_OP});
    end
    bus.req = '0;
    tick;
    checks++;
    if ({bus.gnt, bus.alu_start, bus.rsp_valid} !== '0) begin
      errors++;
      $display("FAIL add_issue got %b want 0",
               {bus.gnt, bus.alu_start, bus.rsp_valid});
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0001, 16'd300, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp got %b %0d %b want 0001 300 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !== '0) begin
      errors++;
      $display("FAIL add_rsp_clear got %h want 0",
               {bus.rsp_valid, bus.rsp_result, bus.rsp_err});
    end
  endtask

  task automatic test_mul;
    set_op(2, 8'hFF, 8'hFF, MUL_OP);
    bus.req = 4'b0100;
    tick;
    m_last = 2;
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mul_gnt got %b want 0100", bus.gnt);
    end
    bus.req = '0;
    tick;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0100, 16'hFE01, 1'b0}) begin
      errors++;
      $display("FAIL mul_rsp got %b %h %b want 0100 fe01 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int i = 0; i < NREQ; i++)
      set_op(i, 8'(10 + i), 8'(3 * i + 1), ADD_OP);
    bus.req = '1;
    for (int g = 0; g < 5; g++) begin
      int w;
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = g % NREQ;
`endif
      m_last = w;
      tick;
      checks++;
      if ({bus.gnt, bus.alu_start} !== {oh(w), 1'b1}) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b want %b", g, bus.gnt, oh(w));
      end
      tick;
      checks++;
      if (bus.gnt !== '0) begin
        errors++;
        $display("FAIL rr_gap%0d got %b want 0", g, bus.gnt);
      end
      tick;
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
          {oh(w), 16'(10 + w + 3 * w + 1), 1'b0}) begin
        errors++;
        $display("FAIL rr_rsp%0d got %b %0d want %b %0d", g, bus.rsp_valid,
                 bus.rsp_result, oh(w), 10 + w + 3 * w + 1);
      end
    end
    bus.req = '0;
    tick;
  endtask

  task automatic test_timeout;
    logic quiet;
    set_op(1, 8'h5A, 8'h11, NO_OP);
    set_op(2, 8'd40, 8'd2, ADD_OP);
    bus.req = 4'b0010;
    tick;
    m_last = 1;
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL to_gnt got %b want 0010", bus.gnt);
    end
    bus.req = 4'b0100;
    tick;
    quiet = 1'b1;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      tick;
      if (bus.rsp_valid !== '0 || bus.gnt !== '0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL to_early got rsp before %0d wait cycles want none",
               TIMEOUT);
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0010, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL to_rsp got %b %h %b want 0010 0000 1",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
    tick;
    m_last = 2;
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL to_next_gnt got %b want 0100", bus.gnt);
    end
    bus.req = '0;
    tick;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0100, 16'd42, 1'b0}) begin
      errors++;
      $display("FAIL to_next_rsp got %b %0d %b want 0100 42 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
  endtask

  task automatic test_reset_mid;
    logic quiet;
    set_op(0, 8'h01, 8'h02, NO_OP);
    bus.req = 4'b0001;
    tick;
    bus.req = '0;
    tick;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.alu_a,
         bus.alu_b, bus.alu_op, bus.alu_start} !== '0) begin
      errors++;
      $display("FAIL midrst_async got nonzero outputs want 0");
    end
    tick;
    tick;
    reset_n = 1'b1;
    m_last = NREQ - 1;
    quiet = 1'b1;
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      tick;
      if (bus.rsp_valid !== '0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rsp got stale response want none");
    end
    set_op(0, 8'd5, 8'd6, ADD_OP);
    set_op(3, 8'd7, 8'd8, ADD_OP);
    bus.req = 4'b1001;
    tick;
    m_last = 0;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr got %b want 0001", bus.gnt);
    end
    bus.req = 4'b1000;
    tick;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result} !== {4'b0001, 16'd11}) begin
      errors++;
      $display("FAIL midrst_rsp0 got %b %0d want 0001 11",
               bus.rsp_valid, bus.rsp_result);
    end
    tick;
    m_last = 3;
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_gnt3 got %b want 1000", bus.gnt);
    end
    bus.req = '0;
    tick;
    tick;
  endtask

  task automatic test_late_req;
    set_op(0, 8'd7, 8'd9, ADD_OP);
    set_op(1, 8'd50, 8'd8, SUB_OP);
    bus.req = 4'b0001;
    tick;
    m_last = 0;
    bus.req = '0;
    tick;
    bus.req = 4'b0010;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.gnt} !== {4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL late_wait got rsp %b gnt %b want 0001 0000",
               bus.rsp_valid, bus.gnt);
    end
    tick;
    m_last = 1;
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL late_gnt got %b want 0010", bus.gnt);
    end
    bus.req = '0;
    tick;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result} !== {4'b0010, 16'd42}) begin
      errors++;
      $display("FAIL late_rsp got %b %0d want 0010 42",
               bus.rsp_valid, bus.rsp_result);
    end
  endtask

  task automatic test_spurious_done;
    bus.req = '0;
    spur = 1'b1;
    tick;
    tick;
    spur = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.gnt} !== '0) begin
      errors++;
      $display("FAIL spur_idle got %b want 0", {bus.rsp_valid, bus.gnt});
    end
    set_op(2, 8'd30, 8'd12, ADD_OP);
    bus.req = 4'b0100;
    tick;
    m_last = 2;
    bus.req = '0;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    checks++;
    if (bus.rsp_valid !== '0) begin
      errors++;
      $display("FAIL spur_issue got %b want 0000", bus.rsp_valid);
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0100, 16'd42, 1'b0}) begin
      errors++;
      $display("FAIL spur_rsp got %b %0d %b want 0100 42 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
  endtask

  task automatic test_done_vs_timeout;
    set_op(1, 8'h12, 8'h34, NO_OP);
    bus.req = 4'b0010;
    tick;
    m_last = 1;
    bus.req = '0;
    tick;
    for (int c = 0; c < TIMEOUT - 1; c++) tick;
    spur = 1'b1;
    tick;
    spur = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !==
        {4'b0010, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL done_wins got %b %h %b want 0010 1234 0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
  endtask

  task automatic test_random;
    logic [NREQ-1:0] pend;
    pend = '0;
    bus.req = '0;
    repeat (40) begin
      logic [NREQ-1:0] nw;
      int w;
      int lat;
      int n;
      logic got;
      logic stray;
      logic [15:0] er;
      logic ee;
      nw = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (nw[i] && !pend[i]) begin
          set_op(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        w = $urandom_range(0, NREQ - 1);
        set_op(w, 8'($urandom), 8'($urandom), ADD_OP);
        pend[w] = 1'b1;
      end
      bus.req = pend;
      w = exp_winner(pend);
      m_last = w;
      tick;
      checks++;
      if (bus.gnt !== oh(w)) begin
        errors++;
        $display("FAIL rnd_gnt got %b want %b", bus.gnt, oh(w));
      end
      pend[w] = 1'b0;
      bus.req = pend;
      if (has_done(rop[w])) begin
        lat = 2;
        er = alu_f(rop[w], ra[w], rb[w]);
        ee = 1'b0;
      end else begin
        lat = 1 + TIMEOUT;
        er = '0;
        ee = 1'b1;
      end
      n = 0;
      got = 1'b0;
      stray = 1'b0;
      while (n < TIMEOUT + 3 && !got) begin
        tick;
        n++;
        if (bus.rsp_valid !== '0) got = 1'b1;
        else if (bus.gnt !== '0) stray = 1'b1;
      end
      checks++;
      if (!got || stray || n != lat ||
          {bus.rsp_valid, bus.rsp_result, bus.rsp_err} !== {oh(w), er, ee}) begin
        errors++;
        $display("FAIL rnd_rsp got %b %h %b lat %0d want %b %h %b lat %0d",
                 bus.rsp_valid, bus.rsp_result, bus.rsp_err, n,
                 oh(w), er, ee, lat);
      end
    end
    bus.req = '0;
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single_add;
    test_mul;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    test_late_req;
    test_spurious_done;
    test_done_vs_timeout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu instance between NREQ independent requesters.
- Round-robin arbitration; latches the winner's operands and opcode; pulses the ALU start for one cycle; waits for done; routes the 16-bit result back to the winner.
- Watchdog timeout returns an error response for opcodes that never assert done (`no_op`, undefined codes).
- Sits between the requester agents and the alu; owns all alu input pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 4, WAIT-state cycles without alu_done before error response (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held with operands stable until gnt.
- req_a  in  NREQ*8  operand A, requester i at bits [8i+7:8i].
- req_b  in  NREQ*8  operand B, same packing.
- req_op  in  NREQ*3  opcode, requester i at bits [3i+2:3i]; encodings per macro.sv.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the originating requester.
- rsp_result  out  16  result, valid while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag, valid while rsp_valid is nonzero.
- alu_a  out  8  to alu A.
- alu_b  out  8  to alu B.
- alu_op  out  3  to alu op.
- alu_start  out  1  to alu start.
- alu_result  in  16  from alu result.
- alu_done  in  1  from alu done.

Behaviour:
- All outputs are registered. On reset, every output is 0; state is IDLE; RR pointer last = NREQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, req != 0 at the edge:
  - Winner w = first set bit searching from last+1 upward, wrapping.
  - Latch req_a/req_b/req_op of w into alu_a/alu_b/alu_op.
  - gnt[w] <= 1; alu_start <= 1; last <= w; go to ISSUE.
- IDLE, req == 0: stay; alu_start = 0.
- ISSUE (exactly one cycle): gnt <= 0; alu_start <= 0; wait counter <= 0; go to WAIT.
  - The alu samples start at this edge; its done appears during the WAIT cycle.
- WAIT:
  - alu_done = 1: rsp_valid[w] <= 1; rsp_result <= alu_result; rsp_err <= 0; go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done: rsp_valid[w] <= 1; rsp_result <= 0; rsp_err <= 1; go to IDLE.
- rsp_valid, rsp_result and rsp_err return to 0 the cycle after the pulse.
- Latency: req sampled at edge n; gnt and alu_start high after edge n; rsp_valid high after edge n+2 (done path). Peak throughput is one operation per 3 cycles.
- alu_a/alu_b/alu_op hold their last values outside ISSUE; they change only on a grant.
- Requests:
  - Asserted during ISSUE/WAIT: not sampled; they wait for IDLE.
  - req of the in-flight requester still high in IDLE: treated as a new request, arbitrated normally (RR then favours the others).
  - Dropped before the IDLE edge: no grant, no response.
- Simultaneous alu_done and timeout terminal count: done wins, rsp_err = 0.
- Spurious alu_done in IDLE or ISSUE: ignored.
- Reset asserted mid-operation: FSM forced to IDLE immediately; in-flight operation discarded; no response is ever issued for it.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requester always wins; pointer `last` is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Single add: req[0]=1, A=8'd200, B=8'd100, op=`add_op` -> gnt[0] one cycle; alu_start one cycle; 2 cycles later rsp_valid=4'b0001, rsp_result=16'd300, rsp_err=0.
- Mul on requester 2: A=8'hFF, B=8'hFF, op=`mul_op` -> rsp_valid=4'b0100, rsp_result=16'hFE01.
- Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0; each gnt 3 cycles apart; responses in the same order. With ALU_ARB_FIXED_PRIO_EN defined -> requester 0 granted every time.
- Timeout: op=`no_op` from requester 1 -> alu_done stays 0; after TIMEOUT WAIT cycles rsp_valid=4'b0010, rsp_err=1, rsp_result=0; arbiter returns to IDLE and serves the next request.
- Reset mid-op: reset_n=0 during WAIT -> all outputs 0 asynchronously; no rsp_valid after release; next req[3] granted first only if requesters 0..2 are idle (pointer reset to NREQ-1).
- Late request: req[1] rises during WAIT of requester 0 -> not granted until IDLE; gnt[1] appears the cycle after rsp_valid[0].
